// File: rtl/packet_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// packet_unpacker_pkg
// Shared packet layout constants, the unpacker FSM state type and small helper
// functions. The packet constructor uses the same field definitions, so both
// ends agree on where the header, hit slots and flag bits sit.
//
// Packet layout (51 bits):
//   [50:35] L0ID/BCID header
//   [34:27] hit0, [26:19] hit1, [18:11] hit2, [10:3] hit3
//   [2] NO_0_1, [1] OVERFLOW, [0] NOT_EMPTY
// A hit value of 8'h00 marks an unused slot.
// -----------------------------------------------------------------------------
package packet_unpacker_pkg;

  localparam int PKT_W     = 51;
  localparam int HDR_W     = 16;
  localparam int HIT_W     = 8;
  localparam int NUM_SLOTS = 4;

  localparam int HDR_MSB   = 50;
  localparam int HDR_LSB   = 35;
  localparam int HIT0_MSB  = 34;

  localparam int FLAG_NO01 = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_NE   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    HIT  = 2'd2
  } state_t;

  // Extract hit slot idx from a packet; slot 0 is the most significant hit.
  function automatic logic [HIT_W-1:0] slot_value(input logic [PKT_W-1:0] pkt,
                                                  input logic [1:0]       idx);
    slot_value = pkt[HIT0_MSB -: HIT_W];
    case (idx)
      2'd1: slot_value = pkt[HIT0_MSB - HIT_W   -: HIT_W];
      2'd2: slot_value = pkt[HIT0_MSB - 2*HIT_W -: HIT_W];
      2'd3: slot_value = pkt[HIT0_MSB - 3*HIT_W -: HIT_W];
      default: slot_value = pkt[HIT0_MSB -: HIT_W];
    endcase
  endfunction

  function automatic logic [2:0] count_slots(input logic [NUM_SLOTS-1:0] mask);
    count_slots = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      count_slots = count_slots + {2'b00, mask[k]};
    end
  endfunction

  // A gap-free mask is a run of ones starting at bit 0 (0000, 0001, 0011, ...).
  // Adding one to such a mask clears every set bit, so any overlap between
  // mask and mask+1 means a valid slot sits above an unused one.
  function automatic logic has_gap(input logic [NUM_SLOTS-1:0] mask);
    logic [NUM_SLOTS-1:0] inc;
    inc     = mask + NUM_SLOTS'(1);
    has_gap = |(mask & inc);
  endfunction

endpackage

// File: rtl/packet_unpacker_slot_sel.sv
// -----------------------------------------------------------------------------
// pkt_slot_sel
// Combinational priority finder over the valid-slot mask. Returns the lowest
// valid slot whose index is >= start_idx, and whether no valid slot lies above
// it (i.e. the returned slot is the packet's final hit).
//
// Ports:
//   mask      valid-slot mask, bit k = slot k
//   start_idx first slot index eligible (0..4; 4 means none eligible)
//   next_idx  lowest eligible valid slot (0 when none exists)
//   last      no eligible valid slot above next_idx
// -----------------------------------------------------------------------------
module pkt_slot_sel
  import packet_unpacker_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [2:0]           start_idx,
  output logic [1:0]           next_idx,
  output logic                 last
);

  logic [NUM_SLOTS-1:0] cand;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cand
    assign cand[gi] = mask[gi] & (3'(gi) >= start_idx);
  end

  always_comb begin
    next_idx = '0;
    // Scan downward so the lowest candidate wins.
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (cand[k]) begin
        next_idx = 2'(k);
      end
    end
    last = 1'b1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (cand[k] && (2'(k) > next_idx)) begin
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/packet_unpacker.sv
// -----------------------------------------------------------------------------
// packet_unpacker
// Accepts one 51-bit packet at a time and emits it as a stream of 16-bit beats:
// one header beat (L0ID/BCID) followed by one beat per valid hit slot, lowest
// slot first, skipping unused (8'h00) slots. A new packet can be accepted in the
// same cycle the final beat is taken, giving bubble-free back-to-back packets.
//
// Ports:
//   CLK, RST          clock; asynchronous active-low reset
//   PCKT_I/VLD/RDY    packet input with valid/ready handshake
//   OUT_DATA/TYPE     beat payload; TYPE 0 = header, 1 = hit
//   OUT_VLD/RDY/LAST  beat handshake and end-of-packet marker
//   FLAGS_O           {NO_0_1, OVERFLOW, NOT_EMPTY} of the current packet
//   HIT_CNT           number of valid hit slots in the current packet
//   ERR_GAP           one-cycle pulse when a valid slot sits above a zero slot
// -----------------------------------------------------------------------------
module packet_unpacker
  import packet_unpacker_pkg::*;
#(
  parameter int CLSTR_NUM = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PKT_W-1:0] PCKT_I,
  input  logic             PCKT_VLD,
  output logic             PCKT_RDY,
  output logic [HDR_W-1:0] OUT_DATA,
  output logic             OUT_TYPE,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  output logic             OUT_LAST,
  output logic [2:0]       FLAGS_O,
  output logic [2:0]       HIT_CNT,
  output logic             ERR_GAP
);

  state_t               state_reg;
  logic [PKT_W-1:0]     pkt_reg;
  logic [NUM_SLOTS-1:0] mask_reg;
  logic [1:0]           idx_reg;

  logic [NUM_SLOTS-1:0] mask_in;
  logic [2:0]           sel_start;
  logic [1:0]           sel_idx;
  logic                 sel_last;
  logic                 beat_done;
  logic                 take;

  // Valid-slot mask of the incoming packet; slots beyond CLSTR_NUM never count.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_mask
    if (gi < CLSTR_NUM) begin : g_used
      assign mask_in[gi] = PCKT_I[FLAG_NE] &
                           (PCKT_I[HIT0_MSB - gi*HIT_W -: HIT_W] != '0);
    end else begin : g_unused
      assign mask_in[gi] = 1'b0;
    end
  end

  assign beat_done = OUT_VLD & OUT_RDY;
  // Ready in IDLE, or while the final beat is being taken so the next packet
  // slides straight into the header beat.
  assign PCKT_RDY  = (state_reg == IDLE) | (beat_done & OUT_LAST);
  assign take      = PCKT_VLD & PCKT_RDY;

  assign FLAGS_O   = {pkt_reg[FLAG_NO01], pkt_reg[FLAG_OVF], pkt_reg[FLAG_NE]};

  // From the header, search from slot 0; from a hit, search above the
  // slot currently on the output.
  assign sel_start = (state_reg == HIT) ? ({1'b0, idx_reg} + 3'd1) : 3'd0;

  pkt_slot_sel u_slot_sel (
    .mask      (mask_reg),
    .start_idx (sel_start),
    .next_idx  (sel_idx),
    .last      (sel_last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      pkt_reg   <= '0;
      mask_reg  <= '0;
      idx_reg   <= '0;
      OUT_VLD   <= 1'b0;
      OUT_TYPE  <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_DATA  <= '0;
      HIT_CNT   <= '0;
      ERR_GAP   <= 1'b0;
    end else begin
      ERR_GAP <= 1'b0;
      if (take) begin
        state_reg <= HDR;
        pkt_reg   <= PCKT_I;
        mask_reg  <= mask_in;
        idx_reg   <= '0;
        HIT_CNT   <= count_slots(mask_in);
        ERR_GAP   <= has_gap(mask_in);
        OUT_VLD   <= 1'b1;
        OUT_TYPE  <= 1'b0;
        OUT_DATA  <= PCKT_I[HDR_MSB:HDR_LSB];
        OUT_LAST  <= (mask_in == '0);
      end else if (beat_done) begin
        case (state_reg)
          HDR, HIT: begin
            if (OUT_LAST) begin
              state_reg <= IDLE;
              OUT_VLD   <= 1'b0;
              OUT_LAST  <= 1'b0;
            end else begin
              state_reg <= HIT;
              idx_reg   <= sel_idx;
              OUT_TYPE  <= 1'b1;
              OUT_DATA  <= {{(HDR_W-HIT_W){1'b0}}, slot_value(pkt_reg, sel_idx)};
              OUT_LAST  <= sel_last;
            end
          end
          default: begin
            state_reg <= IDLE;
            OUT_VLD   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
